pattern_streamer: RTL and testbench
===================================

Name: pattern_streamer

Overview:
- Parametrised pattern generator.
- Holds a writable pattern memory and steps through it at a programmable rate.
- Modes: one-shot, loop, ping-pong, hold.
- Each step presents the pattern word and emits a prefixed byte on a valid/ready stream for a UART transmitter.
- Sits between board control inputs (switch, rate) and the UART TX / LED / debug-header outputs; replaces the fixed divider+counter+ROM chain.

Parameters:
- DataWidth, 4, pattern word width; legal range 1..8.
- AddrWidth, 6, pattern memory address width; Depth = 2**AddrWidth, minimum AddrWidth 1.
- DivWidth, 14, width of the step-rate divider.
- Prefix, 8'h40, byte template; upper 8-DataWidth bits are placed above the pattern word.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  high: divider runs and steps occur; low: divider and address frozen
- mode  in  2  00 one-shot, 01 loop, 10 ping-pong, 11 hold
- restart  in  1  single-cycle pulse; rewinds the sequence
- rate_div  in  DivWidth  step period minus 1, in clk cycles
- wr_en  in  1  pattern memory write strobe
- wr_addr  in  AddrWidth  write address
- wr_data  in  DataWidth  write data
- tx_data  out  8  {Prefix[7:DataWidth], pattern word}
- tx_valid  out  1  byte available
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready
- pattern_out  out  DataWidth  last emitted pattern word (LED drive)
- addr_out  out  AddrWidth  address of the next word to be emitted
- done  out  1  one-shot sequence finished
- overrun  out  1  sticky: a step was dropped because the sink stalled

Behaviour:
- Reset (async assert, sync release): tx_data=0, tx_valid=0, pattern_out=0, addr_out=0, done=0, overrun=0, divider=0, direction=up, state RUN.
- Memory contents are not reset; the bench writes them before use.
- Divider:
  - While enable=1, counts 0..rate_div.
  - On the cycle it equals rate_div it produces a tick and reloads 0.
  - rate_div=0 gives a tick every enabled cycle.
  - A rate_div change takes effect when the count next passes it. If the count is already above the new value, it counts to all-ones and wraps to 0.
- Step on tick at cycle T, state RUN, with the slot free:
  - Slot free means tx_valid=0, or tx_valid && tx_ready in cycle T.
  - At T+1: tx_valid=1, tx_data={Prefix[7:DataWidth], mem[addr_out at T]}, pattern_out=mem[addr_out at T]. Latency is 1 cycle.
  - addr_out advances at T+1 per mode:
    - one-shot: +1. At Depth-1, addr holds, state goes to DONE and done=1.
    - loop: +1, wrapping Depth-1 -> 0.
    - ping-pong: sequence 0,1,..,Depth-1,Depth-2,..,1,0,1,..; endpoints are not repeated and direction flips at the ends. With Depth=2 it alternates 0,1.
    - hold: addr unchanged; the same word is re-emitted every tick.
- Tick with slot busy (tx_valid && !tx_ready): step dropped, addr unchanged, overrun set to 1 and held until restart or reset.
- tx_valid and tx_data are held stable until accepted. tx_valid falls the cycle after acceptance unless a new step loads in that same cycle, so back-to-back bytes are allowed.
- DONE: ticks are ignored and no further bytes are emitted.
- Direction register is forced to up whenever mode != ping-pong. A mode change applies from the next tick.
- restart:
  - addr_out=0, direction=up, divider=0, done=0, overrun=0, state RUN.
  - A pending tx byte is not withdrawn; it completes its handshake.
  - restart coincident with a tick: restart wins and no step is taken.
- Memory write: takes effect the next cycle. A read of the same address in the same cycle returns the old word (read-first).
- enable=0: the pending handshake still completes; done, addr and pattern_out hold.

Test Plan:
- AddrWidth=2, write mem = 1,2,3,4; loop, rate_div=2, tx_ready=1 -> tx_data 0x41,0x42,0x43,0x44,0x41 accepted at 3-cycle intervals; first byte valid one cycle after the first tick.
- Same memory, ping-pong -> byte sequence 0x41,0x42,0x43,0x44,0x43,0x42,0x41,0x42; addr_out tracks 1,2,3,2,1,0,1.
- One-shot -> exactly 4 bytes; done=1 after the 4th step; addr_out=3; further ticks emit nothing; restart -> done=0 and the sequence repeats from 0x41.
- tx_ready=0 for 10 cycles, rate_div=2 -> first byte held stable, overrun=1, addr_out not advanced past 1; release tx_ready -> 0x41 accepted, streaming resumes with 0x42.
- rate_div=0, tx_ready=1, loop -> a byte is accepted every cycle with no overrun; write mem[2]=0xF mid-run -> the next pass emits 0x4F.
- Assert rst_n low asynchronously mid-handshake (between clock edges) -> all outputs 0 immediately; after release the first byte is 0x41.

Source files
------------

// File: rtl/pattern_streamer.sv
// Pattern generator: steps through a writable pattern memory at a programmable
// rate and streams each word, with a fixed prefix, as a byte on a valid/ready port.
module pattern_streamer #(
  parameter int         DataWidth = 4,
  parameter int         AddrWidth = 6,
  parameter int         DivWidth  = 14,
  parameter logic [7:0] Prefix    = 8'h40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 restart,
  input  logic [DivWidth-1:0]  rate_div,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [DataWidth-1:0] pattern_out,
  output logic [AddrWidth-1:0] addr_out,
  output logic                 done,
  output logic                 overrun
);

  localparam int Depth = 2 ** AddrWidth;
  localparam logic [AddrWidth-1:0] LastAddr = {AddrWidth{1'b1}};

  typedef enum logic [1:0] {
    ModeOneShot  = 2'b00,
    ModeLoop     = 2'b01,
    ModePingPong = 2'b10,
    ModeHold     = 2'b11
  } mode_e;

  typedef enum logic {
    StRun,
    StDone
  } state_e;

  logic [DataWidth-1:0] mem [Depth];

  state_e               state_q, state_d;
  logic [DivWidth-1:0]  div_q, div_d;
  logic                 dir_down_q, dir_down_d;
  logic [AddrWidth-1:0] addr_d;
  logic [7:0]           tx_data_d;
  logic                 tx_valid_d;
  logic [DataWidth-1:0] pattern_d;
  logic                 overrun_d;

  logic                 tick;
  logic                 slot_free;
  logic                 step;
  logic                 drop;
  logic [DataWidth-1:0] rd_word;
  logic [7:0]           tx_byte;
  mode_e                mode_cur;

  // NOTE: the pattern memory has no reset; it is write-before-use storage, and
  // leaving it out of the reset domain lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read of the registered array gives read-first behaviour on
  // a same-cycle write to the address being stepped.
  assign rd_word  = mem[addr_out];
  assign mode_cur = mode_e'(mode);

  always_comb begin
    tx_byte                = Prefix;
    tx_byte[DataWidth-1:0] = rd_word;
  end

  assign tick      = enable && (div_q == rate_div);
  assign slot_free = !tx_valid || tx_ready;
  assign step      = tick && (state_q == StRun) && slot_free && !restart;
  assign drop      = tick && (state_q == StRun) && !slot_free && !restart;
  assign done      = (state_q == StDone);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    dir_down_d = dir_down_q;
    addr_d     = addr_out;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid && !tx_ready;
    pattern_d  = pattern_out;
    overrun_d  = overrun || drop;

    // Reload only on an exact match, so a count already past a lowered
    // rate_div runs on to all-ones and wraps naturally.
    if (enable) begin
      div_d = tick ? '0 : div_q + DivWidth'(1);
    end

    if (step) begin
      tx_valid_d = 1'b1;
      tx_data_d  = tx_byte;
      pattern_d  = rd_word;
      unique case (mode_cur)
        ModeOneShot: begin
          if (addr_out == LastAddr) begin
            state_d = StDone;
          end else begin
            addr_d = addr_out + AddrWidth'(1);
          end
        end
        ModeLoop: addr_d = addr_out + AddrWidth'(1);
        ModePingPong: begin
          if (!dir_down_q) begin
            if (addr_out == LastAddr) begin
              addr_d     = addr_out - AddrWidth'(1);
              dir_down_d = 1'b1;
            end else begin
              addr_d = addr_out + AddrWidth'(1);
            end
          end else begin
            if (addr_out == '0) begin
              addr_d     = addr_out + AddrWidth'(1);
              dir_down_d = 1'b0;
            end else begin
              addr_d = addr_out - AddrWidth'(1);
            end
          end
        end
        ModeHold: addr_d = addr_out;
        default:  addr_d = addr_out;
      endcase
    end

    if (mode_cur != ModePingPong) begin
      dir_down_d = 1'b0;
    end

    // A pending byte is left in place so its handshake can still complete.
    if (restart) begin
      state_d    = StRun;
      div_d      = '0;
      dir_down_d = 1'b0;
      addr_d     = '0;
      overrun_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      div_q       <= '0;
      dir_down_q  <= 1'b0;
      addr_out    <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      pattern_out <= '0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      dir_down_q  <= dir_down_d;
      addr_out    <= addr_d;
      tx_data     <= tx_data_d;
      tx_valid    <= tx_valid_d;
      pattern_out <= pattern_d;
      overrun     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_pattern_streamer.sv
// Scoreboard bench for pattern_streamer (Depth 4): directed stimulus pushes
// expected bytes, a monitor pops and compares on every accepted handshake.
module tb_pattern_streamer;

  localparam int DataWidth = 4;
  localparam int AddrWidth = 2;
  localparam int DivWidth  = 14;

  logic                 clk;
  logic                 rst_n;
  logic                 enable;
  logic [1:0]           mode;
  logic                 restart;
  logic [DivWidth-1:0]  rate_div;
  logic                 wr_en;
  logic [AddrWidth-1:0] wr_addr;
  logic [DataWidth-1:0] wr_data;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DataWidth-1:0] pattern_out;
  logic [AddrWidth-1:0] addr_out;
  logic                 done;
  logic                 overrun;

  pattern_streamer #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth),
    .DivWidth (DivWidth),
    .Prefix   (8'h40)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .restart    (restart),
    .rate_div   (rate_div),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .pattern_out(pattern_out),
    .addr_out   (addr_out),
    .done       (done),
    .overrun    (overrun)
  );

  // Expected byte, address after the step (-1: don't care) and cycles since
  // the previous accepted byte (0: don't care).
  typedef struct {
    logic [7:0] data;
    int         addr;
    int         gap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  int   last_acc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic push(input logic [7:0] d, input int a, input int g);
    sb.push_back('{data: d, addr: a, gap: g});
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte: got 0x%0h expected no byte at cycle %0d", tx_data, cycle);
      end else begin
        mon_e = sb.pop_front();
        check("tx_data", 32'(tx_data), 32'(mon_e.data));
        check("pattern_out", 32'(pattern_out), 32'(mon_e.data[DataWidth-1:0]));
        if (mon_e.addr >= 0) check("addr_out", 32'(addr_out), 32'(mon_e.addr));
        if (mon_e.gap > 0) check("accept_gap", 32'(cycle - last_acc), 32'(mon_e.gap));
      end
      last_acc = cycle;
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic pulse_restart();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
  endtask

  task automatic write_mem(input logic [AddrWidth-1:0] a, input logic [DataWidth-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 2'b01; restart = 1'b0; rate_div = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; tx_ready = 1'b0;
    #12 rst_n = 1'b1;

    @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_pattern", 32'(pattern_out), 32'h0);
    check("rst_addr", 32'(addr_out), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    for (int i = 0; i < 4; i++) write_mem(AddrWidth'(i), DataWidth'(i + 1));

    // Loop mode, one step every 3 cycles.
    push(8'h41, 1, 0); push(8'h42, 2, 3); push(8'h43, 3, 3);
    push(8'h44, 0, 3); push(8'h41, 1, 3);
    @(posedge clk); #1;
    mode = 2'b01; rate_div = 14'd2; tx_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("first_latency_idle", 32'(tx_valid), 32'h0);
    end
    @(negedge clk);
    check("first_latency_valid", 32'(tx_valid), 32'h1);
    check("first_addr", 32'(addr_out), 32'h1);
    wait_drain(40);
    enable = 1'b0;

    // Ping-pong.
    pulse_restart();
    mode = 2'b10;
    push(8'h41, 1, 0); push(8'h42, 2, 3); push(8'h43, 3, 3); push(8'h44, 2, 3);
    push(8'h43, 1, 3); push(8'h42, 0, 3); push(8'h41, 1, 3); push(8'h42, 2, 3);
    enable = 1'b1;
    wait_drain(60);
    enable = 1'b0;

    // One-shot, then restart repeats the sequence.
    pulse_restart();
    mode = 2'b00;
    push(8'h41, 1, 0); push(8'h42, 2, 3); push(8'h43, 3, 3); push(8'h44, 3, 3);
    enable = 1'b1;
    wait_drain(40);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("oneshot_done", 32'(done), 32'h1);
    check("oneshot_addr", 32'(addr_out), 32'h3);
    check("oneshot_idle", 32'(tx_valid), 32'h0);
    push(8'h41, 1, 0); push(8'h42, 2, 3); push(8'h43, 3, 3); push(8'h44, 3, 3);
    pulse_restart();
    check("restart_done", 32'(done), 32'h0);
    check("restart_addr", 32'(addr_out), 32'h0);
    wait_drain(40);
    check("oneshot_done2", 32'(done), 32'h1);
    enable = 1'b0;

    // Sink stall: first byte held, later ticks dropped.
    pulse_restart();
    mode = 2'b01; tx_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(tx_valid), (i >= 3) ? 32'h1 : 32'h0);
      if (i >= 3) check("stall_data", 32'(tx_data), 32'h41);
    end
    check("stall_overrun", 32'(overrun), 32'h1);
    check("stall_addr", 32'(addr_out), 32'h1);
    push(8'h41, 1, 0); push(8'h42, 2, 0); push(8'h43, 3, 3);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_drain(40);
    enable = 1'b0;
    check("overrun_sticky", 32'(overrun), 32'h1);
    pulse_restart();
    check("overrun_cleared", 32'(overrun), 32'h0);

    // Full rate with a read-first write to the address being stepped.
    rate_div = 14'd0;
    push(8'h41, 1, 0); push(8'h42, 2, 1); push(8'h43, 3, 1); push(8'h44, 0, 1);
    push(8'h41, 1, 1); push(8'h42, 2, 1); push(8'h4F, 3, 1); push(8'h44, 0, 1);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'hF;
    @(posedge clk); #1 wr_en = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    enable = 1'b0;
    wait_drain(20);
    check("fullrate_overrun", 32'(overrun), 32'h0);

    // Asynchronous reset in the middle of a pending handshake.
    pulse_restart();
    rate_div = 14'd2; tx_ready = 1'b0; enable = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    check("pre_reset_valid", 32'(tx_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("areset_tx_data", 32'(tx_data), 32'h0);
    check("areset_tx_valid", 32'(tx_valid), 32'h0);
    check("areset_pattern", 32'(pattern_out), 32'h0);
    check("areset_addr", 32'(addr_out), 32'h0);
    check("areset_done", 32'(done), 32'h0);
    check("areset_overrun", 32'(overrun), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    push(8'h41, 1, 0);
    tx_ready = 1'b1;
    rst_n = 1'b1;
    wait_drain(20);
    enable = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
